// File: rtl/snd_i2s_tx.sv
// I2S transmitter: fall-through sample FIFO feeding a clock-enable driven serializer
// that generates MCLK/BCLK/LRCLK/DOUT from the single ACLK domain.
`timescale 1ns/1ps
module snd_i2s_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 32,
    parameter int FIFO_AW   = 6,
    parameter int BCLK_HALF = 4,
    parameter int MCLK_HALF = 1
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic                    ENABLE,
    input  logic                    MONO,
    input  logic                    MUTE,
    input  logic                    WR_EN,
    input  logic [2*SAMPLE_W-1:0]   WR_DATA,
    input  logic                    CLR_FLAGS,
    output logic                    FULL,
    output logic [FIFO_AW:0]        LEVEL,
    output logic                    SND_FIFO_UNDER,
    output logic                    SND_FIFO_OVER,
    output logic                    SND_MCLK,
    output logic                    SND_BCLK,
    output logic                    SND_LRCLK,
    output logic                    SND_DOUT
);

    localparam int FW    = 2 * SAMPLE_W;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int KW    = $clog2(2 * SLOT_W);
    localparam int BDW   = $clog2(BCLK_HALF + 1);
    localparam int MDW   = $clog2(MCLK_HALF + 1);

    localparam logic [KW-1:0]    K_LAST   = KW'(2 * SLOT_W - 1);
    localparam logic [KW-1:0]    LR_LO    = KW'(SLOT_W - 1);
    localparam logic [KW-1:0]    LR_HI    = KW'(2 * SLOT_W - 2);
    localparam logic [BDW-1:0]   B_LAST   = BDW'(BCLK_HALF - 1);
    localparam logic [MDW-1:0]   M_LAST   = MDW'(MCLK_HALF - 1);
    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

    logic [FW-1:0]      mem_q [DEPTH];
    logic [FW-1:0]      mem_d [DEPTH];
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [MDW-1:0]     mdiv_q, mdiv_d;
    logic [BDW-1:0]     bdiv_q, bdiv_d;
    logic               mclk_q, mclk_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               dout_q, dout_d;
    logic               under_q, under_d;
    logic               over_q, over_d;
    logic [KW-1:0]      k_q, k_d;
    logic [FW-1:0]      frame_q, frame_d;

    logic [FIFO_AW:0]   level;
    logic               empty;
    logic               full;
    logic               fall;
    logic               load;
    logic               pop;
    logic               wr_acc;
    logic [FW-1:0]      loaded;
    logic [2*SLOT_W-1:0] ser;

    always_comb begin
        level  = wr_ptr_q - rd_ptr_q;
        empty  = (level == '0);
        full   = (level == FULL_LVL);
        fall   = ENABLE && bclk_q && (bdiv_q == B_LAST);
        load   = fall && (k_q == K_LAST);
        pop    = load && !empty;
        // A write into a full FIFO is still accepted when the head leaves this cycle.
        wr_acc = WR_EN && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            mem_d[wr_ptr_q[FIFO_AW-1:0]] = WR_DATA;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        loaded = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
        if (MONO) begin
            loaded[SAMPLE_W-1:0] = loaded[FW-1:SAMPLE_W];
        end
        if (MUTE) begin
            loaded = '0;
        end
        frame_d = load ? loaded : frame_q;

        mdiv_d  = '0;
        bdiv_d  = '0;
        mclk_d  = 1'b0;
        bclk_d  = 1'b0;
        k_d     = K_LAST;
        lrclk_d = 1'b0;
        dout_d  = 1'b0;
        ser     = '0;
        if (ENABLE) begin
            mclk_d  = mclk_q;
            bclk_d  = bclk_q;
            k_d     = k_q;
            lrclk_d = lrclk_q;
            dout_d  = dout_q;
            if (mdiv_q == M_LAST) begin
                mclk_d = ~mclk_q;
            end else begin
                mdiv_d = mdiv_q + 1'b1;
            end
            if (bdiv_q == B_LAST) begin
                bclk_d = ~bclk_q;
            end else begin
                bdiv_d = bdiv_q + 1'b1;
            end
            if (fall) begin
                k_d = load ? '0 : k_q + 1'b1;
                // Frame laid out in transmit order: bit (2*SLOT_W-1-k) goes out at index k.
                ser[2*SLOT_W-1 -: SAMPLE_W] = frame_d[FW-1:SAMPLE_W];
                ser[SLOT_W-1 -: SAMPLE_W]   = frame_d[SAMPLE_W-1:0];
                dout_d  = ser[K_LAST - k_d];
                lrclk_d = (k_d >= LR_LO) && (k_d <= LR_HI);
            end
        end

        under_d = under_q;
        over_d  = over_q;
        if (CLR_FLAGS) begin
            under_d = 1'b0;
            over_d  = 1'b0;
        end
        if (load && empty && !MUTE) begin
            under_d = 1'b1;
        end
        if (WR_EN && full && !pop) begin
            over_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mdiv_q   <= '0;
            bdiv_q   <= '0;
            mclk_q   <= 1'b0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            dout_q   <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            k_q      <= K_LAST;
            frame_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mdiv_q   <= mdiv_d;
            bdiv_q   <= bdiv_d;
            mclk_q   <= mclk_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            dout_q   <= dout_d;
            under_q  <= under_d;
            over_q   <= over_d;
            k_q      <= k_d;
            frame_q  <= frame_d;
        end
    end

    assign FULL           = full;
    assign LEVEL          = level;
    assign SND_FIFO_UNDER = under_q;
    assign SND_FIFO_OVER  = over_q;
    assign SND_MCLK       = mclk_q;
    assign SND_BCLK       = bclk_q;
    assign SND_LRCLK      = lrclk_q;
    assign SND_DOUT       = dout_q;

endmodule

// File: doc/snd_i2s_tx.md
# snd_i2s_tx

Parametrised I2S transmitter for the sound subsystem: a sample FIFO followed by a clock-enable-driven serializer producing SND_MCLK, SND_BCLK, SND_LRCLK and SND_DOUT from a single clock. It sits between the sound DMA/register logic, which writes samples, and the audio codec pins. It adds configurable sample/slot width, FIFO depth, clock dividers, mono/mute modes, sticky under/overflow flags and a level readout.

## Interface
- SAMPLE_W, 16: bits per channel sample, 8..32.
- SLOT_W, 32: BCLKs per channel slot, at least SAMPLE_W.
- FIFO_AW, 6: FIFO depth = 2**FIFO_AW frames.
- BCLK_HALF, 4: ACLK cycles per BCLK half-period, at least 1.
- MCLK_HALF, 1: ACLK cycles per MCLK half-period, at least 1.
- ACLK  in  1  sole clock, all logic on rising edge.
- ARST  in  1  reset, synchronous, active-high.
- ENABLE  in  1  run serializer; 0 = clocks and data idle.
- MONO  in  1  1 = left half of each frame sent on both channels.
- MUTE  in  1  1 = frames still consumed, DOUT forced 0.
- WR_EN  in  1  write strobe, one frame per cycle.
- WR_DATA  in  2*SAMPLE_W  frame: left in [2*SAMPLE_W-1:SAMPLE_W], right in [SAMPLE_W-1:0], two's complement.
- CLR_FLAGS  in  1  clears sticky flags.
- FULL  out  1  FIFO full.
- LEVEL  out  FIFO_AW+1  frames held.
- SND_FIFO_UNDER  out  1  sticky underflow.
- SND_FIFO_OVER  out  1  sticky overflow.
- SND_MCLK, SND_BCLK, SND_LRCLK, SND_DOUT  out  1 each  codec pins, all registered.

## Operation
- Reset values (ARST=1 at an ACLK edge): all outputs 0, LEVEL=0, FIFO empty, frame index k=2*SLOT_W-1, dividers 0. Reset mid-frame aborts the frame and discards FIFO contents.
- FIFO: first-word fall-through, registered head.
  - Write with FULL=0 is accepted.
  - Write with FULL=1 is dropped and sets OVER, except when a pop occurs the same cycle. In that case the write is accepted, no OVER is set, and LEVEL is unchanged.
  - Writes are accepted regardless of ENABLE.
- Clocking while ENABLE=1:
  - MCLK toggles every MCLK_HALF cycles.
  - BCLK toggles every BCLK_HALF cycles.
  - A BCLK falling event is the cycle BCLK goes 1->0.
- ENABLE=0: dividers are held at 0, MCLK, BCLK, LRCLK and DOUT are 0, and k=2*SLOT_W-1. Deasserting ENABLE mid-frame abandons the frame; the popped frame is lost.
- On each BCLK falling event, k advances modulo 2*SLOT_W. When k wraps to 0 a frame load happens:
  - FIFO non-empty: pop the head into the shift frame.
  - FIFO empty: load zeros; if MUTE=0, set UNDER.
  - MONO=1: the right-slot sample is a copy of the loaded left sample.
  - MUTE=1: the frame is popped as normal, but the shift frame is zeroed.
- DOUT at index k:
  - k<SAMPLE_W: left bit SAMPLE_W-1-k.
  - SLOT_W<=k<SLOT_W+SAMPLE_W: right bit SAMPLE_W-1-(k-SLOT_W).
  - Otherwise 0.
- LRCLK=1 iff SLOT_W-1 <= k <= 2*SLOT_W-2. This gives the standard I2S one-BCLK lead: left is low, right is high.
- Flags stay set until CLR_FLAGS. If CLR_FLAGS and a set event occur in the same cycle, set wins.

## Timing
- DOUT and LRCLK change in the cycle of a BCLK falling event and are stable across the following rising edge; the codec samples on the rising edge.
- After ENABLE rises (cycle 0), the first BCLK rise is at cycle BCLK_HALF. The first falling event is at cycle 2*BCLK_HALF; it loads frame k=0 and drives the left MSB.
- Frame period is 2*SLOT_W*2*BCLK_HALF ACLK cycles. The pop occurs exactly once per frame, in the load cycle.
- Write to LEVEL/FULL latency: 1 cycle. The written frame can be popped at the next load from the following cycle onward.
- Arithmetic:
  - LEVEL = writes accepted minus pops, in 0..2**FIFO_AW.
  - FULL = (LEVEL == 2**FIFO_AW).
  - FIFO pointers wrap modulo 2**FIFO_AW and use an extra MSB for full/empty.

## Test plan
Bench parameters: SAMPLE_W=16, SLOT_W=32, BCLK_HALF=2, FIFO_AW=2.
- Stereo serial: write 0xA5A5_0F0F, ENABLE=1.
  - Required: at the first falling event DOUT=1 (left MSB); bits 0..15 are 1010010110100101; bits 16..31 are 0.
  - LRCLK rises at k=31; the right slot carries 0000111100001111.
  - Frame length is 256 ACLK cycles.
- Underflow: ENABLE with an empty FIFO.
  - Required: DOUT stays 0 and UNDER=1 after the first load.
  - CLR_FLAGS clears it; it is set again at the next load. With MUTE=1 it is never set.
- Overflow: ENABLE=0, write 5 frames.
  - Required: FULL=1 after the 4th write, LEVEL=4, OVER=1 after the 5th, and the 5th frame is absent from the output.
- Write while full coinciding with a pop: FIFO full, write issued in the load cycle.
  - Required: OVER stays 0, LEVEL stays 4, and the new frame appears 4 frames later.
- Mono and mute: MONO=1 with frame 0x8001_1234.
  - Required: both slots carry 0x8001.
  - With MUTE=1, DOUT=0 and LEVEL drops by 1 per frame.
- Reset mid-frame: ARST at k=10 with LEVEL=3.
  - Required: next cycle all outputs 0, LEVEL=0, flags 0.
  - After release with ENABLE=1, timing restarts as specified from cycle 0.
